// File: rtl/current_adc_reader_if.sv
// Bundles the control inputs, the serial ADC bus and the sample outputs of
// current_adc_reader.
//   enable        : high permits periodic conversions
//   channel[2:0]  : ADC mux address sent in each frame
//   adc_dout      : serial data from the ADC
//   adc_cs_n      : ADC chip select, active-low
//   adc_sclk      : serial clock, idles high
//   adc_din       : serial control word to the ADC
//   current_b_out : last captured 12-bit sample
//   sample_valid  : one-cycle strobe when current_b_out updates
//   busy          : high while adc_cs_n is low
// The slave modport is the reader's view; the master modport is the view of
// whatever drives enable/channel and plays the ADC.
interface current_adc_reader_if;
    logic        enable;
    logic [2:0]  channel;
    logic        adc_dout;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_din;
    logic [11:0] current_b_out;
    logic        sample_valid;
    logic        busy;

    modport slave (
        input  enable,
        input  channel,
        input  adc_dout,
        output adc_cs_n,
        output adc_sclk,
        output adc_din,
        output current_b_out,
        output sample_valid,
        output busy
    );

    modport master (
        output enable,
        output channel,
        output adc_dout,
        input  adc_cs_n,
        input  adc_sclk,
        input  adc_din,
        input  current_b_out,
        input  sample_valid,
        input  busy
    );
endinterface

// File: rtl/current_adc_reader.sv
// Periodic SPI reader for a 12-bit current-sense ADC.
// Every SAMPLE_PERIOD clk cycles (while enabled) one frame is run:
//   SETUP (CLK_DIV cycles, SCLK high) -> SHIFT (16 SCLK periods, low then
//   high, CLK_DIV cycles each half) -> HOLD (CLK_DIV cycles, SCLK high).
// The control word {2'b00, channel, 11'b0} goes out MSB first, changing on
// SCLK falling edges; ADC data is sampled on SCLK rising edges and the last
// 12 bits (periods 4..15) form the sample.
// Ports:
//   clk  : single clock, posedge
//   rst  : asynchronous active-high reset
//   bus  : current_adc_reader_if.slave (enable, channel, ADC serial pins,
//          current_b_out, sample_valid, busy)
// Parameters:
//   CLK_DIV       : clk cycles per SCLK half-period (>= 2)
//   SAMPLE_PERIOD : clk cycles between conversion starts (>= 35*CLK_DIV)
module current_adc_reader #(
    parameter int CLK_DIV       = 25,
    parameter int SAMPLE_PERIOD = 5000
) (
    input  logic                       clk,
    input  logic                       rst,
    current_adc_reader_if.slave        bus
);

    localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [4:0]        HALF_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [TICK_W-1:0] tick_r;
    logic [TICK_W-1:0] tick_next_s;
    logic [4:0]        half_r;        // SCLK half-period index inside SHIFT
    logic [4:0]        half_next_s;
    logic              tick_end_s;
    logic [CNT_W-1:0]  period_cnt_r;

    logic [2:0]        chan_r;
    logic [2:0]        chan_next_s;
    logic [15:0]       ctrl_word_s;
    logic [11:0]       shift_r;
    logic [11:0]       shift_next_s;
    logic              sample_now_s;

    logic              cs_n_r;
    logic              cs_n_next_s;
    logic              sclk_r;
    logic              sclk_next_s;
    logic              din_r;
    logic              din_next_s;
    logic [11:0]       data_r;
    logic [11:0]       data_next_s;
    logic              valid_r;
    logic              valid_next_s;
    logic              busy_r;
    logic              busy_next_s;

    assign tick_end_s = (tick_r == TICK_LAST);

    // Conversion period counter; held at zero while disabled so that a rising
    // enable starts a frame on the very next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt_r <= CNT_ZERO;
        end else if (!bus.enable) begin
            period_cnt_r <= CNT_ZERO;
        end else if (period_cnt_r == CNT_LAST) begin
            period_cnt_r <= CNT_ZERO;
        end else begin
            period_cnt_r <= period_cnt_r + CNT_ONE;
        end
    end

    // FSM state register with its phase counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            tick_r  <= TICK_ZERO;
            half_r  <= 5'd0;
        end else begin
            state_r <= state_next_s;
            tick_r  <= tick_next_s;
            half_r  <= half_next_s;
        end
    end

    // FSM next-state logic. A counter wrap seen outside IDLE is simply lost.
    always_comb begin
        state_next_s = state_r;
        tick_next_s  = tick_r;
        half_next_s  = half_r;
        case (state_r)
            IDLE: begin
                if (bus.enable && (period_cnt_r == CNT_ZERO)) begin
                    state_next_s = SETUP;
                    tick_next_s  = TICK_ZERO;
                    half_next_s  = 5'd0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETUP: begin
                if (tick_end_s) begin
                    state_next_s = SHIFT;
                    tick_next_s  = TICK_ZERO;
                    half_next_s  = 5'd0;
                end else begin
                    tick_next_s = tick_r + TICK_ONE;
                end
            end
            SHIFT: begin
                if (tick_end_s) begin
                    tick_next_s = TICK_ZERO;
                    if (half_r == HALF_LAST) begin
                        state_next_s = HOLD;
                        half_next_s  = 5'd0;
                    end else begin
                        half_next_s = half_r + 5'd1;
                    end
                end else begin
                    tick_next_s = tick_r + TICK_ONE;
                end
            end
            HOLD: begin
                if (tick_end_s) begin
                    state_next_s = IDLE;
                    tick_next_s  = TICK_ZERO;
                end else begin
                    tick_next_s = tick_r + TICK_ONE;
                end
            end
            default: begin
                state_next_s = IDLE;
                tick_next_s  = TICK_ZERO;
                half_next_s  = 5'd0;
            end
        endcase
    end

    // Output logic: next values of every pin, derived from the next state so
    // the registered pins line up exactly with the state they belong to.
    always_comb begin
        // Channel is captured on the edge that leaves IDLE and frozen after.
        if ((state_r == IDLE) && (state_next_s == SETUP)) begin
            chan_next_s = bus.channel;
        end else begin
            chan_next_s = chan_r;
        end
        ctrl_word_s = {2'b00, chan_next_s, 11'b000_0000_0000};

        cs_n_next_s = (state_next_s == IDLE);
        busy_next_s = (state_next_s != IDLE);

        // Even half-periods are the low phase of SCLK.
        if (state_next_s == SHIFT) begin
            sclk_next_s = half_next_s[0];
        end else begin
            sclk_next_s = 1'b1;
        end

        // Period k (half-periods 2k and 2k+1) carries bit 15-k, so din only
        // moves when a low phase begins.
        case (state_next_s)
            SETUP:   din_next_s = ctrl_word_s[15];
            SHIFT:   din_next_s = ctrl_word_s[4'd15 - half_next_s[4:1]];
            default: din_next_s = 1'b0;
        endcase

        // SCLK rises when a low half-period ends; the first four periods are
        // leading zeros from the ADC and are not kept.
        sample_now_s = (state_r == SHIFT) && tick_end_s && !half_r[0];
        if (sample_now_s && (half_r[4:1] >= 4'd4)) begin
            shift_next_s = {shift_r[10:0], bus.adc_dout};
        end else begin
            shift_next_s = shift_r;
        end

        // The visible sample only changes as the frame closes, never mid-shift.
        valid_next_s = (state_r == HOLD) && tick_end_s;
        if (valid_next_s) begin
            data_next_s = shift_r;
        end else begin
            data_next_s = data_r;
        end
    end

    // Output and datapath registers; reset parks the bus in its idle levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_n_r  <= 1'b1;
            sclk_r  <= 1'b1;
            din_r   <= 1'b0;
            data_r  <= 12'd0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            shift_r <= 12'd0;
            chan_r  <= 3'd0;
        end else begin
            cs_n_r  <= cs_n_next_s;
            sclk_r  <= sclk_next_s;
            din_r   <= din_next_s;
            data_r  <= data_next_s;
            valid_r <= valid_next_s;
            busy_r  <= busy_next_s;
            shift_r <= shift_next_s;
            chan_r  <= chan_next_s;
        end
    end

    assign bus.adc_cs_n      = cs_n_r;
    assign bus.adc_sclk      = sclk_r;
    assign bus.adc_din       = din_r;
    assign bus.current_b_out = data_r;
    assign bus.sample_valid  = valid_r;
    assign bus.busy          = busy_r;

endmodule

// File: tb/tb_current_adc_reader.sv
// Testbench for current_adc_reader (CLK_DIV=2, SAMPLE_PERIOD=100).
// A monitor plays the ADC (4 zero bits then the 12-bit value) and records
// frame events; expected samples are queued at each CS fall and compared
// against the recorded strobes by the scenario tasks.
module tb_current_adc_reader;

    logic clk = 1'b0;
    logic rst;

    current_adc_reader_if bus();

    current_adc_reader #(
        .CLK_DIV(2),
        .SAMPLE_PERIOD(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Monitor / ADC model state
    int          cyc = 0;
    bit          prev_cs = 1'b1;
    bit          prev_sclk = 1'b1;
    bit          in_frame = 1'b0;
    int          fall_cyc = 0;
    int          falls = 0;
    int          frames_done = 0;
    int          strobes = 0;
    int          sclk_rises = 0;
    int          adc_bit = 0;
    logic [15:0] din_word = 16'd0;
    int          last_low = 0;
    int          last_rises = 0;
    logic [15:0] last_din = 16'd0;
    logic [11:0] adc_cur = 12'd0;

    logic [11:0] adc_q[$];     // values the ADC model will return
    logic [11:0] exp_q[$];     // scoreboard: expected sample per frame
    logic [11:0] val_q[$];     // current_b_out seen at each strobe
    int          strobe_q[$];
    int          fall_q[$];

    // Monitor and ADC model, sampled 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (rst) begin
                in_frame     = 1'b0;
                prev_cs      = 1'b1;
                prev_sclk    = 1'b1;
                bus.adc_dout = 1'b0;
            end else begin
                if (prev_cs && !bus.adc_cs_n) begin
                    if (adc_q.size() > 1) adc_cur = adc_q.pop_front();
                    else if (adc_q.size() == 1) adc_cur = adc_q[0];
                    exp_q.push_back(adc_cur);
                    fall_q.push_back(cyc);
                    fall_cyc   = cyc;
                    falls      = falls + 1;
                    in_frame   = 1'b1;
                    sclk_rises = 0;
                    din_word   = 16'd0;
                    adc_bit    = 0;
                end
                if (in_frame && !prev_sclk && bus.adc_sclk) begin
                    sclk_rises = sclk_rises + 1;
                    din_word   = {din_word[14:0], bus.adc_din};
                end
                if (in_frame && prev_sclk && !bus.adc_sclk) begin
                    if (adc_bit < 4) bus.adc_dout = 1'b0;
                    else bus.adc_dout = adc_cur[15 - adc_bit];
                    adc_bit = adc_bit + 1;
                end
                if (in_frame && !prev_cs && bus.adc_cs_n) begin
                    in_frame    = 1'b0;
                    last_low    = cyc - fall_cyc;
                    last_rises  = sclk_rises;
                    last_din    = din_word;
                    frames_done = frames_done + 1;
                end
                if (bus.sample_valid === 1'b1) begin
                    strobes = strobes + 1;
                    strobe_q.push_back(cyc);
                    val_q.push_back(bus.current_b_out);
                end
                prev_cs   = bus.adc_cs_n;
                prev_sclk = bus.adc_sclk;
            end
        end
    end

    task automatic clear_queues();
        exp_q.delete();
        val_q.delete();
        strobe_q.delete();
        fall_q.delete();
        adc_q.delete();
    endtask

    task automatic wait_frames(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frames_done >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_falls(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (falls >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.enable  = 1'b0;
        bus.channel = 3'b000;
        repeat (3) @(negedge clk);
        checks++; if (bus.adc_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got=%b exp=1", bus.adc_cs_n); end
        checks++; if (bus.adc_sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk got=%b exp=1", bus.adc_sclk); end
        checks++; if (bus.adc_din !== 1'b0) begin errors++; $display("FAIL reset_din got=%b exp=0", bus.adc_din); end
        checks++; if (bus.current_b_out !== 12'h000) begin errors++; $display("FAIL reset_data got=%h exp=000", bus.current_b_out); end
        checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.sample_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        bit ok;
        int f0;
        int s0;
        int st;
        int fc;
        logic [11:0] ev;
        logic [11:0] gv;
        clear_queues();
        adc_q.push_back(12'hA5C);
        bus.channel = 3'b101;
        f0 = frames_done;
        s0 = strobes;
        bus.enable = 1'b1;
        wait_falls(falls + 1, 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_start got=no_cs_fall exp=cs_fall"); end
        repeat (20) @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.adc_cs_n !== 1'b0) begin errors++; $display("FAIL single_busy got=busy%b/cs%b exp=busy1/cs0", bus.busy, bus.adc_cs_n); end
        checks++; if (bus.current_b_out !== 12'h000) begin errors++; $display("FAIL single_no_partial got=%h exp=000", bus.current_b_out); end
        wait_frames(f0 + 1, 100, ok);
        bus.enable = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL single_done got=timeout exp=frame_end"); end
        repeat (5) @(negedge clk);
        checks++; if (last_low != 68) begin errors++; $display("FAIL single_cs_low got=%0d exp=68", last_low); end
        checks++; if (last_rises != 16) begin errors++; $display("FAIL single_sclk_rises got=%0d exp=16", last_rises); end
        checks++; if (last_din !== 16'b0010100000000000) begin errors++; $display("FAIL single_din got=%b exp=0010100000000000", last_din); end
        checks++; if (strobes - s0 != 1) begin errors++; $display("FAIL single_strobes got=%0d exp=1", strobes - s0); end
        checks++;
        if (val_q.size() == 0 || exp_q.size() == 0 || strobe_q.size() == 0 || fall_q.size() == 0) begin
            errors++; $display("FAIL single_value got=no_strobe exp=%h", 12'hA5C);
        end else begin
            ev = exp_q.pop_front(); gv = val_q.pop_front();
            st = strobe_q.pop_front(); fc = fall_q.pop_front();
            if (gv !== ev) begin errors++; $display("FAIL single_value got=%h exp=%h", gv, ev); end
            checks++; if (st - fc != 68) begin errors++; $display("FAIL single_strobe_time got=%0d exp=68", st - fc); end
        end
        checks++; if (bus.current_b_out !== 12'hA5C || bus.busy !== 1'b0) begin errors++; $display("FAIL single_hold got=%h/busy%b exp=a5c/busy0", bus.current_b_out, bus.busy); end
    endtask

    task automatic test_periodic();
        bit ok;
        int f0;
        int s0;
        int n0;
        clear_queues();
        adc_q.push_back(12'h000);
        adc_q.push_back(12'hFFF);
        adc_q.push_back(12'h9C4);
        bus.channel = 3'b010;
        f0 = frames_done;
        s0 = strobes;
        n0 = falls;
        bus.enable = 1'b1;
        repeat (350) @(negedge clk);
        bus.enable = 1'b0;
        wait_frames(f0 + 4, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL periodic_done got=%0d exp=4 frames", frames_done - f0); end
        repeat (5) @(negedge clk);
        checks++; if (strobes - s0 != 4 || falls - n0 != 4) begin errors++; $display("FAIL periodic_count got=%0d strobes/%0d falls exp=4/4", strobes - s0, falls - n0); end
        if (val_q.size() == 4 && exp_q.size() == 4 && strobe_q.size() == 4 && fall_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (val_q[i] !== exp_q[i]) begin errors++; $display("FAIL periodic_value%0d got=%h exp=%h", i, val_q[i], exp_q[i]); end
                checks++; if (strobe_q[i] - fall_q[0] != 68 + 100 * i) begin errors++; $display("FAIL periodic_strobe_time%0d got=%0d exp=%0d", i, strobe_q[i] - fall_q[0], 68 + 100 * i); end
                checks++; if (fall_q[i] - fall_q[0] != 100 * i) begin errors++; $display("FAIL periodic_start%0d got=%0d exp=%0d", i, fall_q[i] - fall_q[0], 100 * i); end
            end
        end else begin
            checks++; errors++;
            $display("FAIL periodic_queues got=%0d samples exp=4", val_q.size());
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int f0;
        int n1;
        clear_queues();
        adc_q.push_back(12'h3C7);
        bus.channel = 3'b011;
        f0 = frames_done;
        bus.enable = 1'b1;
        wait_falls(falls + 1, 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_start got=no_cs_fall exp=cs_fall"); end
        repeat (30) @(negedge clk);
        bus.enable = 1'b0;
        wait_frames(f0 + 1, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_complete got=aborted exp=frame_end"); end
        checks++;
        if (val_q.size() == 0 || exp_q.size() == 0 || strobe_q.size() == 0 || fall_q.size() == 0) begin
            errors++; $display("FAIL drop_value got=no_strobe exp=%h", 12'h3C7);
        end else begin
            if (val_q[0] !== exp_q[0]) begin errors++; $display("FAIL drop_value got=%h exp=%h", val_q[0], exp_q[0]); end
            checks++; if (strobe_q[0] - fall_q[0] != 68) begin errors++; $display("FAIL drop_strobe_time got=%0d exp=68", strobe_q[0] - fall_q[0]); end
        end
        n1 = falls;
        repeat (500) @(negedge clk);
        checks++; if (falls != n1 || bus.adc_cs_n !== 1'b1) begin errors++; $display("FAIL drop_no_restart got=%0d falls exp=0", falls - n1); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int s0;
        int f0;
        int rel;
        clear_queues();
        adc_q.push_back(12'h5A5);
        bus.channel = 3'b001;
        bus.enable = 1'b1;
        wait_falls(falls + 1, 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_start got=no_cs_fall exp=cs_fall"); end
        repeat (40) @(negedge clk);
        s0 = strobes;
        rst = 1'b1;
        #1;
        checks++; if (bus.adc_cs_n !== 1'b1 || bus.adc_sclk !== 1'b1) begin errors++; $display("FAIL rstmid_async got=cs%b/sclk%b exp=cs1/sclk1", bus.adc_cs_n, bus.adc_sclk); end
        checks++; if (bus.current_b_out !== 12'h000 || bus.busy !== 1'b0 || bus.adc_din !== 1'b0) begin errors++; $display("FAIL rstmid_outputs got=%h/busy%b/din%b exp=000/busy0/din0", bus.current_b_out, bus.busy, bus.adc_din); end
        repeat (3) @(negedge clk);
        checks++; if (strobes != s0) begin errors++; $display("FAIL rstmid_no_strobe got=%0d exp=0", strobes - s0); end
        exp_q.delete();
        val_q.delete();
        strobe_q.delete();
        fall_q.delete();
        f0 = frames_done;
        rel = cyc;
        rst = 1'b0;
        wait_falls(falls + 1, 5, ok);
        checks++;
        if (!ok || fall_q.size() == 0) begin
            errors++; $display("FAIL rstmid_restart got=no_cs_fall exp=cs_fall");
        end else if (fall_q[0] != rel + 1) begin
            errors++; $display("FAIL rstmid_restart got=%0d exp=%0d", fall_q[0] - rel, 1);
        end
        wait_frames(f0 + 1, 100, ok);
        bus.enable = 1'b0;
        checks++;
        if (!ok || val_q.size() == 0 || exp_q.size() == 0) begin
            errors++; $display("FAIL rstmid_value got=no_strobe exp=%h", 12'h5A5);
        end else if (val_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL rstmid_value got=%h exp=%h", val_q[0], exp_q[0]);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_channel_toggle();
        bit ok;
        int f0;
        clear_queues();
        adc_q.push_back(12'h123);
        bus.channel = 3'b110;
        f0 = frames_done;
        bus.enable = 1'b1;
        wait_falls(falls + 1, 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL chan_start got=no_cs_fall exp=cs_fall"); end
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.channel = ~bus.channel;
            if (frames_done >= f0 + 1) begin
                ok = 1'b1;
                break;
            end
        end
        bus.enable = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL chan_done got=timeout exp=frame_end"); end
        checks++; if (last_din !== 16'b0011000000000000) begin errors++; $display("FAIL chan_din got=%b exp=0011000000000000", last_din); end
        checks++;
        if (val_q.size() == 0 || exp_q.size() == 0) begin
            errors++; $display("FAIL chan_value got=no_strobe exp=%h", 12'h123);
        end else if (val_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL chan_value got=%h exp=%h", val_q[0], exp_q[0]);
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_periodic();
        test_enable_drop();
        test_reset_mid_frame();
        test_channel_toggle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/current_adc_reader.md
CURRENT_ADC_READER -- requirements
Module: current_adc_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25, meaning clk cycles per SCLK half-period; legal range ≥2.
REQ-002 SHALL have parameter SAMPLE_PERIOD, default 5000, meaning clk cycles between conversion starts; legal range ≥ 34*CLK_DIV+CLK_DIV.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic rises on posedge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port enable, input, 1 bit: high permits periodic conversions.
REQ-006 SHALL have port channel, input, 3 bits: ADC mux address sent in each frame.
REQ-007 SHALL have port adc_dout, input, 1 bit: serial data from ADC.
REQ-008 SHALL have port adc_cs_n, output, 1 bit: ADC chip select, active-low.
REQ-009 SHALL have port adc_sclk, output, 1 bit: serial clock, idles high.
REQ-010 SHALL have port adc_din, output, 1 bit: serial control word to ADC.
REQ-011 SHALL have port current_b_out, output, 12 bits: last captured sample, unsigned.
REQ-012 SHALL have port sample_valid, output, 1 bit: one-cycle strobe when current_b_out updates.
REQ-013 SHALL have port busy, output, 1 bit: high while adc_cs_n is low.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, SHIFT, HOLD.
REQ-015 Period counter SHALL count 0..SAMPLE_PERIOD-1 and wrap while enable=1, and SHALL clear to 0 and hold while enable=0.
REQ-016 IDLE->SETUP SHALL occur when enable=1, counter=0 and state=IDLE; adc_cs_n falls on that cycle's next edge, and channel is latched on the same edge.
REQ-017 SETUP SHALL last CLK_DIV cycles with adc_sclk=1, adc_din = control bit 15.
REQ-018 SHIFT SHALL generate exactly 16 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
REQ-019 Control word SHALL be {2'b00, latched channel, 11'b0}, MSB first; adc_din SHALL change only on SCLK falling edges, so bit 15-k is valid during period k (k=0..15).
REQ-020 adc_dout SHALL be sampled on each SCLK rising edge; bits from periods 0..3 are discarded, and periods 4..15 SHALL shift in D11..D0, MSB first.
REQ-021 HOLD SHALL last CLK_DIV cycles with adc_sclk=1 and adc_cs_n=0; total adc_cs_n low time is 34*CLK_DIV cycles.
REQ-022 On HOLD exit, adc_cs_n SHALL rise, current_b_out SHALL load the 12-bit shift register, and sample_valid SHALL be 1 for exactly that one cycle; state returns to IDLE.
REQ-023 current_b_out SHALL hold its value between strobes and SHALL never show partially shifted data.
REQ-024 enable falling mid-frame SHALL NOT abort the frame; the frame completes with a strobe, and no new frame starts.
REQ-025 A counter=0 event while not IDLE SHALL be ignored; no queued start.
REQ-026 channel changes mid-frame SHALL NOT affect the current frame.
REQ-027 busy SHALL equal ~adc_cs_n, registered, with no glitches.
REQ-028 All outputs SHALL be driven directly from flops.

Reset
REQ-029 While rst=1, all outputs SHALL be forced: adc_cs_n=1, adc_sclk=1, adc_din=0, current_b_out=12'd0, sample_valid=0, busy=0; state is IDLE and counters are 0.
REQ-030 Reset asserted mid-frame SHALL raise adc_cs_n immediately (asynchronously); no strobe is issued for the aborted frame.
REQ-031 After rst falls with enable=1, the first frame SHALL start on the first posedge where counter=0, i.e. the first clk edge after release.

Verification (CLK_DIV=2, SAMPLE_PERIOD=100, ADC model returns 4 zero bits then the 12-bit value)
REQ-032 Single frame: ADC value 12'hA5C, channel=3'b101 -> adc_cs_n low 68 cycles, 16 SCLK rises, adc_din pattern 0010100000000000, current_b_out=12'hA5C, one sample_valid pulse.
REQ-033 Periodic: enable held high 350 cycles, ADC values 12'h000, 12'hFFF, 12'h9C4 -> frames start 100 cycles apart, 4 strobes at cycles 68, 168, 268, 368 relative to first CS fall, values in order (4th value repeats the model's last).
REQ-034 Enable drop at cycle 30 of frame -> frame completes, strobe at cycle 68, no further CS fall for 500 cycles.
REQ-035 rst pulse at cycle 40 of frame -> adc_cs_n=1 and adc_sclk=1 within same cycle, current_b_out=0, no strobe; the next frame starts right after release.
REQ-036 channel toggled every cycle mid-frame -> adc_din bits 13..11 match the value latched at CS fall.
